fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter TAPS, default 401: tap count of the sequenced fir; sets flush length to TAPS-1 zero samples.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two: input sample FIFO depth.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle job request, honoured only in IDLE.
REQ-006 sample_len  in  16  samples in the job, latched on accepted start.
REQ-007 rate_div  in  8  pacing divider, latched on accepted start; one FIR input per rate_div+1 cycles.
REQ-008 src_valid / src_ready / src_sample  in / out / in  1/1/16  source handshake; transfer when src_valid & src_ready.
REQ-009 fir_in_valid / fir_in_sample  out  1/16  drive fir in_valid/in_sample.
REQ-010 fir_out_valid / fir_out_sample  in  1/16  from fir out_valid/out_sample.
REQ-011 dst_valid / dst_sample  out  1/16  filtered output stream.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done  out  1  one-cycle job-complete pulse.
REQ-014 err  out  1  drain timeout flag, valid with done.

Function
REQ-015 FSM states IDLE, RUN, FLUSH, DRAIN, DONE; DONE lasts exactly one cycle then IDLE.
REQ-016 IDLE: start=1 with sample_len>0 -> RUN next cycle; start=1 with sample_len=0 -> DONE (no FIR traffic); start outside IDLE ignored.
REQ-017 Pacing counter reloads to rate_div on start and after every tick; tick when counter=0; rate_div=0 gives a tick every cycle.
REQ-018 src_ready=1 only in RUN, FIFO not full, and accepted count < sample_len; excess source data never accepted.
REQ-019 RUN: on tick with FIFO non-empty, pop one sample, assert fir_in_valid for exactly one cycle with that sample; tick with FIFO empty issues nothing and is not deferred.
REQ-020 FIFO push and pop in the same cycle both occur; occupancy unchanged; push while full and pop while empty never happen by construction.
REQ-021 RUN -> FLUSH the cycle after the sample_len-th sample is issued.
REQ-022 FLUSH: on each tick issue fir_in_valid=1 with fir_in_sample=0; after TAPS-1 zero issues -> DRAIN.
REQ-023 Issued count (17 bits + TAPS width) increments per fir_in_valid; output count increments per fir_out_valid while busy.
REQ-024 DRAIN -> DONE when output count equals issued count (sample_len+TAPS-1).
REQ-025 dst_valid=fir_out_valid and dst_sample=fir_out_sample combinationally while busy; dst_valid=0 in IDLE regardless of fir_out_valid.
REQ-026 fir_in_sample=0 whenever fir_in_valid=0.
REQ-027 done=1 only in DONE; err updated on DRAIN exit, cleared on next accepted start.

Reset
REQ-028 rst=1 at a clock edge: state IDLE, FIFO emptied, counters cleared, mid-job data discarded.
REQ-029 Outputs during/after reset: src_ready=0, fir_in_valid=0, fir_in_sample=0, dst_valid=0, busy=0, done=0, err=0.
REQ-030 start coincident with rst is ignored.

Configuration
REQ-031 Macro FIR_SEQ_CTRL_TIMEOUT_EN defined: DRAIN watchdog counts cycles since last fir_out_valid; at 1024 -> DONE with err=1.
REQ-032 Macro FIR_SEQ_CTRL_TIMEOUT_EN undefined: no watchdog logic; DRAIN waits indefinitely; err tied 0.

Verification
REQ-033 TAPS=5, rate_div=0, sample_len=3, source always valid with 1,2,3 -> fir_in_valid on 7 consecutive ticks carrying 1,2,3,0,0,0,0; done after 7th fir_out_valid; err=0.
REQ-034 rate_div=3, sample_len=2 -> fir_in_valid pulses exactly 4 cycles apart; src_ready drops after 2nd accepted sample.
REQ-035 Source stalls 20 cycles mid-job -> no fir_in_valid during stall, FIFO empty, job resumes, issued total still sample_len+TAPS-1.
REQ-036 start with sample_len=0 -> busy 1 cycle, done pulse, no fir_in_valid; start asserted in RUN -> ignored, latched values unchanged.
REQ-037 rst asserted in FLUSH -> next cycle IDLE, all outputs at reset values; fresh start runs full job correctly.
REQ-038 With FIR_SEQ_CTRL_TIMEOUT_EN, fir_out_valid withheld in DRAIN -> done and err=1 exactly 1024 cycles after last output; without macro, busy stays 1.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Job sequencer for a streaming FIR: buffers source samples, paces them into the filter,
// appends TAPS-1 zero samples and waits for every output. Optional macro: FIR_SEQ_CTRL_TIMEOUT_EN.
module fir_seq_ctrl #(
  parameter int TAPS       = 401,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] sample_len,
  input  logic [7:0]  rate_div,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [15:0] src_sample,
  output logic        fir_in_valid,
  output logic [15:0] fir_in_sample,
  input  logic        fir_out_valid,
  input  logic [15:0] fir_out_sample,
  output logic        dst_valid,
  output logic [15:0] dst_sample,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 17 + $clog2(TAPS + 1);
  localparam logic [CW-1:0] FLUSH_LEN = CW'(TAPS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

  state_t          state;
  logic [15:0]     len_q;
  logic [7:0]      rate_q;
  logic [7:0]      pace_cnt;
  logic [15:0]     acc_cnt;
  logic [CW-1:0]   issued_cnt;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   out_cnt_nxt;
  logic [CW-1:0]   total;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            tick;
  logic            busy_q;
  logic            done_q;
  logic            fin_v;
  logic [15:0]     fin_s;

  assign total       = CW'(len_q) + FLUSH_LEN;
  assign tick        = (pace_cnt == 8'd0);
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign src_ready   = (state == RUN) && !fifo_full && (acc_cnt < len_q);
  assign push        = src_valid && src_ready;
  assign pop         = (state == RUN) && tick && !fifo_empty;
  assign out_cnt_nxt = out_cnt + {{(CW-1){1'b0}}, fir_out_valid};

  assign fir_in_valid  = fin_v;
  assign fir_in_sample = fin_s;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dst_valid     = busy_q && fir_out_valid;
  assign dst_sample    = busy_q ? fir_out_sample : 16'd0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= src_sample;
  end

`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'd1023;
  logic [9:0] wd_cnt;
  logic       err_q;
  assign err = err_q;

  // wd_cnt holds the number of cycles since the last filter output, saturating at WD_LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if (fir_out_valid) begin
      wd_cnt <= 10'd1;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + 10'd1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fin_v      <= 1'b0;
      fin_s      <= '0;
      len_q      <= '0;
      rate_q     <= '0;
      pace_cnt   <= '0;
      acc_cnt    <= '0;
      issued_cnt <= '0;
      out_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      fin_v  <= 1'b0;
      fin_s  <= '0;
      done_q <= 1'b0;
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        acc_cnt <= acc_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (busy_q && fir_out_valid) out_cnt <= out_cnt_nxt;
      // Ticks keep their rhythm across the RUN to FLUSH boundary
      if (state == RUN || state == FLUSH) pace_cnt <= tick ? rate_q : pace_cnt - 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= sample_len;
            rate_q     <= rate_div;
            pace_cnt   <= rate_div;
            acc_cnt    <= '0;
            issued_cnt <= '0;
            out_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            busy_q     <= 1'b1;
`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            if (sample_len == 16'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop) begin
            fin_v      <= 1'b1;
            fin_s      <= fifo_mem[rd_ptr[AW-1:0]];
            issued_cnt <= issued_cnt + CNT_ONE;
            if (issued_cnt + CNT_ONE == CW'(len_q)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (issued_cnt == total) begin
            state <= DRAIN;
          end else if (tick) begin
            fin_v      <= 1'b1;
            issued_cnt <= issued_cnt + CNT_ONE;
            if (issued_cnt + CNT_ONE == total) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_cnt_nxt == issued_cnt) begin
            state  <= DONE;
            done_q <= 1'b1;
`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
            err_q  <= 1'b0;
          end else if (!fir_out_valid && wd_cnt == WD_LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl (TAPS=5) with a 3-cycle-latency filter stub
// whose outputs can be withheld; checks issue order, pacing, stalls, reset and drain.
module tb_fir_seq_ctrl;

  localparam int TAPS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] sample_len;
  logic [7:0]  rate_div;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] src_sample;
  logic        fir_in_valid;
  logic [15:0] fir_in_sample;
  logic        fir_out_valid;
  logic [15:0] fir_out_sample;
  logic        dst_valid;
  logic [15:0] dst_sample;
  logic        busy;
  logic        done;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc_no = 0;
  logic [15:0] in_q [$];
  int          in_t [$];
  int          out_events, last_out_cyc, done_cnt, done_cyc, busy_cycles, accepted;
  int          bad_zero = 0;
  int          dst_bad = 0;
  logic        done_err;
  logic        src_en;
  int          src_idx, delivered, hold_after;
  logic        pv0, pv1;
  logic [15:0] ps0, ps1;
  logic [15:0] t1_exp [7];

  always #5 clk = ~clk;

  fir_seq_ctrl #(.TAPS(TAPS), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_len(sample_len), .rate_div(rate_div),
    .src_valid(src_valid), .src_ready(src_ready), .src_sample(src_sample),
    .fir_in_valid(fir_in_valid), .fir_in_sample(fir_in_sample),
    .fir_out_valid(fir_out_valid), .fir_out_sample(fir_out_sample),
    .dst_valid(dst_valid), .dst_sample(dst_sample),
    .busy(busy), .done(done), .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] s_at(input int i);
    return (i < in_q.size()) ? 32'(in_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int t_at(input int i);
    return (i < in_t.size()) ? in_t[i] : -100000;
  endfunction

  // One clock: observe at the falling edge, then update source and filter stub after the rising edge
  task automatic run_cycle();
    logic        xfer;
    logic        iv;
    logic [15:0] is;
    @(negedge clk);
    if (fir_in_valid) begin
      in_q.push_back(fir_in_sample);
      in_t.push_back(cyc_no);
    end
    if (!fir_in_valid && fir_in_sample !== 16'd0) bad_zero++;
    if (dst_valid !== (busy && fir_out_valid)) dst_bad++;
    if (busy && dst_valid && dst_sample !== fir_out_sample) dst_bad++;
    if (busy && fir_out_valid) begin
      out_events++;
      last_out_cyc = cyc_no;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_no;
      done_err = err;
    end
    if (busy) busy_cycles++;
    xfer = src_valid && src_ready;
    iv   = fir_in_valid;
    is   = fir_in_sample;
    @(posedge clk);
    #1;
    cyc_no++;
    if (xfer) begin
      accepted++;
      src_idx++;
    end
    src_sample     = 16'(src_idx + 1);
    src_valid      = src_en;
    fir_out_valid  = pv1 && (delivered < hold_after);
    fir_out_sample = fir_out_valid ? 16'(ps1 * 3 + 7) : 16'd0;
    if (fir_out_valid) delivered++;
    pv1 = pv0;
    ps1 = ps0;
    pv0 = iv;
    ps0 = is;
  endtask

  task automatic clear_mon();
    in_q.delete();
    in_t.delete();
    out_events   = 0;
    last_out_cyc = 0;
    done_cnt     = 0;
    done_cyc     = 0;
    done_err     = 1'b0;
    busy_cycles  = 0;
    accepted     = 0;
    src_idx      = 0;
    delivered    = 0;
    hold_after   = 1 << 30;
  endtask

  task automatic applyStimulus(input logic [15:0] len, input logic [7:0] rate);
    clear_mon();
    sample_len = len;
    rate_div   = rate;
    src_en     = 1'b1;
    src_valid  = 1'b1;
    src_sample = 16'd1;
    start      = 1'b1;
    run_cycle();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      run_cycle();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
  endtask

  initial begin
    int n;
    int n0;
    rst = 1'b1; start = 1'b0; sample_len = '0; rate_div = '0;
    src_en = 1'b0; src_valid = 1'b0; src_sample = '0;
    fir_out_valid = 1'b0; fir_out_sample = '0;
    pv0 = 1'b0; pv1 = 1'b0; ps0 = '0; ps1 = '0;
    t1_exp = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
    clear_mon();
    run_cycle();
    run_cycle();
    checkOutput("rst_src_ready", 32'(src_ready), 32'd0);
    checkOutput("rst_fir_in_valid", 32'(fir_in_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    run_cycle();

    // Basic job: three samples at full rate followed by four zeros
    applyStimulus(16'd3, 8'd0);
    wait_done(100, "t1");
    checkOutput("t1_issued", in_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("t1_sample%0d", i), s_at(i), 32'(t1_exp[i]));
    checkOutput("t1_consecutive", t_at(6) - t_at(0), 32'd6);
    checkOutput("t1_accepted", accepted, 32'd3);
    checkOutput("t1_outs", out_events, 32'd7);
    checkOutput("t1_done_after_last_out", done_cyc - last_out_cyc, 32'd1);
    checkOutput("t1_err", 32'(done_err), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Paced job: one filter input every 4 cycles
    applyStimulus(16'd2, 8'd3);
    wait_done(200, "t2");
    checkOutput("t2_issued", in_q.size(), 32'd6);
    for (int i = 1; i < 6; i++) checkOutput($sformatf("t2_gap%0d", i), t_at(i) - t_at(i - 1), 32'd4);
    checkOutput("t2_accepted", accepted, 32'd2);

    // Source stall of 20 cycles after the third accepted sample
    applyStimulus(16'd6, 8'd0);
    n = 0;
    while (accepted < 3 && n < 50) begin
      run_cycle();
      n++;
    end
    checkOutput("t3_reached_stall", accepted, 32'd3);
    src_en    = 1'b0;
    src_valid = 1'b0;
    run_cycle();
    run_cycle();
    n0 = in_q.size();
    repeat (18) run_cycle();
    checkOutput("t3_stall_issues", in_q.size() - n0, 32'd0);
    checkOutput("t3_ready_in_stall", 32'(src_ready), 32'd1);
    src_en    = 1'b1;
    src_valid = 1'b1;
    wait_done(200, "t3");
    checkOutput("t3_issued", in_q.size(), 32'd10);
    checkOutput("t3_last_data", s_at(5), 32'd6);
    checkOutput("t3_first_zero", s_at(6), 32'd0);
    checkOutput("t3_accepted", accepted, 32'd6);

    // Empty job, then a start pulse during RUN that must be ignored
    applyStimulus(16'd0, 8'd0);
    wait_done(10, "t4a");
    checkOutput("t4a_busy_cycles", busy_cycles, 32'd1);
    checkOutput("t4a_no_issue", in_q.size(), 32'd0);
    applyStimulus(16'd2, 8'd3);
    run_cycle();
    run_cycle();
    start = 1'b1; sample_len = 16'd9; rate_div = 8'd0;
    run_cycle();
    start = 1'b0; sample_len = 16'd0;
    wait_done(200, "t4b");
    checkOutput("t4b_issued", in_q.size(), 32'd6);
    checkOutput("t4b_gap_first", t_at(1) - t_at(0), 32'd4);
    checkOutput("t4b_gap_last", t_at(5) - t_at(4), 32'd4);
    checkOutput("t4b_done_count", done_cnt, 32'd1);

    // Reset during FLUSH with a coincident start, then a clean job
    applyStimulus(16'd2, 8'd3);
    n = 0;
    while (in_q.size() < 3 && n < 100) begin
      run_cycle();
      n++;
    end
    checkOutput("t5_in_flush", in_q.size(), 32'd3);
    rst = 1'b1; start = 1'b1; sample_len = 16'd3;
    run_cycle();
    checkOutput("t5_rst_outputs",
                {25'd0, src_ready, fir_in_valid, dst_valid, busy, done, err, |fir_in_sample}, 32'd0);
    rst = 1'b0; start = 1'b0;
    run_cycle();
    checkOutput("t5_start_with_rst_ignored", 32'(busy), 32'd0);
    repeat (4) run_cycle();
    applyStimulus(16'd3, 8'd0);
    wait_done(100, "t5");
    checkOutput("t5_issued", in_q.size(), 32'd7);
    checkOutput("t5_first", s_at(0), 32'd1);
    checkOutput("t5_fourth", s_at(3), 32'd0);
    checkOutput("t5_outs", out_events, 32'd7);

    // Filter stops producing after three outputs while the job drains
    applyStimulus(16'd1, 8'd0);
    hold_after = 3;
`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
    wait_done(1200, "t6");
    checkOutput("t6_outs", out_events, 32'd3);
    checkOutput("t6_err", 32'(done_err), 32'd1);
    checkOutput("t6_timeout_delay", done_cyc - last_out_cyc, 32'd1024);
`else
    repeat (1100) run_cycle();
    checkOutput("t6_outs", out_events, 32'd3);
    checkOutput("t6_still_busy", 32'(busy), 32'd1);
    checkOutput("t6_no_done", done_cnt, 32'd0);
    checkOutput("t6_err", 32'(err), 32'd0);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    checkOutput("t6_reset_busy", 32'(busy), 32'd0);
`endif

    checkOutput("zero_when_not_valid", bad_zero, 32'd0);
    checkOutput("dst_passthrough", dst_bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
